// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module      : logic_gate_unit
// Description : Registered bitwise logic unit with valid/ready handshakes,
//               single-beat streaming and multi-beat accumulate mode.
//               Optional macro LOGIC_UNIT_PARITY_EN adds out_parity.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] out_beats
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    localparam logic       c_IDLE    = 1'b0;
    localparam logic       c_ACCUM   = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_zero;
    logic             r_out_ones;
    logic [CNT_W-1:0] r_out_beats;

    logic             w_accept;
    logic             w_produce;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_f;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_beats_next;

    function automatic logic [WIDTH-1:0] f_logic(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [2:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = x ^ y;
            3'd3:    r = ~(x & y);
            3'd4:    r = ~(x | y);
            3'd5:    r = ~(x ^ y);
            3'd6:    r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign in_ready  = (!r_out_valid || out_ready) && !rst;
    assign w_accept  = in_valid && in_ready;

    // In ACCUM the running value replaces operand A.
    assign w_x       = (r_state == c_ACCUM) ? r_acc : in_a;
    assign w_f       = f_logic(w_x, in_b, in_op);
    assign w_cnt_inc = (r_count == c_CNT_MAX) ? r_count : r_count + c_CNT_ONE;

    assign w_produce    = w_accept && ((r_state == c_IDLE) ? (!in_acc || in_last) : in_last);
    assign w_beats_next = (r_state == c_IDLE) ? c_CNT_ONE : w_cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            case (r_state)
                c_IDLE: begin
                    if (in_acc && !in_last) begin
                        r_acc   <= w_f;
                        r_count <= c_CNT_ONE;
                        r_state <= c_ACCUM;
                    end
                end
                default: begin
                    if (in_last) begin
                        r_acc   <= '0;
                        r_count <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_acc   <= w_f;
                        r_count <= w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_zero  <= 1'b0;
            r_out_ones  <= 1'b0;
            r_out_beats <= '0;
        end else if (w_produce) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_f;
            r_out_zero  <= (w_f == '0);
            r_out_ones  <= &w_f;
            r_out_beats <= w_beats_next;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_parity <= 1'b0;
        end else if (w_produce) begin
            r_out_parity <= ^w_f;
        end
    end

    assign out_parity = r_out_parity;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_zero  = r_out_zero;
    assign out_ones  = r_out_ones;
    assign out_beats = r_out_beats;

endmodule
`default_nettype wire
